// File: rtl/panic_cell_allocator.sv
// panic_cell_allocator
//   Hands out packet-buffer cells to the ingress parser and takes them back
//   when packets finish. Each of the two buffer ports keeps a circular
//   free-list of cell IDs. After reset the lists are filled with every ID, one
//   entry per cycle, before allocation is allowed.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   alloc_mem_req      allocation request from the parser
//   alloc_mem_size     requested packet length in bytes
//   alloc_cell_id      granted cell ID (valid with alloc_mem_success)
//   alloc_port_id      granted port (valid with alloc_mem_success)
//   alloc_mem_success  grant, combinational in the request cycle
//   alloc_mem_intense  registered low-free-space hint
//   free_valid         release request
//   free_ready         release accepted (high once the lists are built)
//   free_cell_id       cell being released
//   free_port_id       port the released cell belongs to
//   free_err           one-cycle pulse after a rejected release
//   init_done          free-lists fully populated
//
// Optional build macro PANIC_ALLOC_STATS_EN adds statistics outputs:
//   stat_alloc_cnt, stat_fail_cnt, stat_free_cnt (saturating) and
//   stat_min_free (low-water mark of total free cells).
module panic_cell_allocator #(
  parameter int LEN_WIDTH      = 16,
  parameter int CELL_ID_WIDTH  = 16,
  parameter int CELLS_PER_PORT = 16,
  parameter int CELL_BYTES     = 2048,
  parameter int INTENSE_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_mem_req,
  input  logic [LEN_WIDTH-1:0]     alloc_mem_size,
  output logic [CELL_ID_WIDTH-1:0] alloc_cell_id,
  output logic                     alloc_port_id,
  output logic                     alloc_mem_success,
  output logic                     alloc_mem_intense,
  input  logic                     free_valid,
  output logic                     free_ready,
  input  logic [CELL_ID_WIDTH-1:0] free_cell_id,
  input  logic                     free_port_id,
  output logic                     free_err,
  output logic                     init_done
`ifdef PANIC_ALLOC_STATS_EN
  ,
  output logic [31:0]              stat_alloc_cnt,
  output logic [31:0]              stat_fail_cnt,
  output logic [31:0]              stat_free_cnt,
  output logic [$clog2(CELLS_PER_PORT)+1:0] stat_min_free
`endif
);

  localparam int IDX_W = $clog2(CELLS_PER_PORT);
  localparam int PTR_W = IDX_W + 1;
  localparam int TOT_W = IDX_W + 2;

  localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(CELLS_PER_PORT - 1);
  localparam logic [PTR_W-1:0]         FULL_CNT  = PTR_W'(CELLS_PER_PORT);
  localparam logic [PTR_W-1:0]         FULL_TAIL = {1'b1, {IDX_W{1'b0}}};
  localparam logic [LEN_WIDTH-1:0]     MAX_LEN   = LEN_WIDTH'(CELL_BYTES);
  localparam logic [CELL_ID_WIDTH:0]   ID_LIMIT  = (CELL_ID_WIDTH+1)'(CELLS_PER_PORT);
  localparam logic [TOT_W-1:0]         THRESH    = TOT_W'(INTENSE_THRESH);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        init_cnt_q, init_cnt_d;
  logic [1:0][PTR_W-1:0]   head_q, head_d;
  logic [1:0][PTR_W-1:0]   tail_q, tail_d;
  logic                    last_port_q, last_port_d;
  logic                    free_err_q, free_err_d;
  logic                    intense_q, intense_d;

  logic [CELL_ID_WIDTH-1:0] cell_mem [2][CELLS_PER_PORT];

  logic [1:0][PTR_W-1:0]   cnt;
  logic [PTR_W-1:0]        cnt_nx0, cnt_nx1;
  logic [TOT_W-1:0]        tot_d;
  logic                    sel;
  logic                    run;
  logic                    free_fire;
  logic                    free_bad;
  logic                    free_push;

  // Port selection uses the counts before this cycle's updates; the fuller
  // port wins and a tie goes to the port not used by the last grant.
  always_comb begin
    cnt[0] = tail_q[0] - head_q[0];
    cnt[1] = tail_q[1] - head_q[1];
    if (cnt[0] > cnt[1]) begin
      sel = 1'b0;
    end else if (cnt[1] > cnt[0]) begin
      sel = 1'b1;
    end else begin
      sel = ~last_port_q;
    end
    free_fire = free_valid && (state_q == ST_RUN);
    free_bad  = ({1'b0, free_cell_id} >= ID_LIMIT) || (cnt[free_port_id] == FULL_CNT);
    free_push = free_fire && !free_bad;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && init_cnt_q == LAST_IDX) begin
      state_d = ST_RUN;
    end
  end

  // FSM outputs
  always_comb begin
    run               = (state_q == ST_RUN);
    init_done         = run;
    free_ready        = run;
    alloc_mem_success = run && alloc_mem_req && (alloc_mem_size != '0) &&
                        (alloc_mem_size <= MAX_LEN) && (cnt[sel] != '0);
    alloc_port_id     = sel;
    alloc_cell_id     = cell_mem[sel][head_q[sel][IDX_W-1:0]];
    free_err          = free_err_q;
    alloc_mem_intense = intense_q;
  end

  // Pointer, init counter and flag updates. The last INIT cycle leaves both
  // lists full: head at 0 and tail at 0 with the wrap bit set.
  always_comb begin
    init_cnt_d  = init_cnt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    last_port_d = last_port_q;
    free_err_d  = 1'b0;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == LAST_IDX) begin
        head_d    = '0;
        tail_d[0] = FULL_TAIL;
        tail_d[1] = FULL_TAIL;
      end
    end else begin
      if (alloc_mem_success) begin
        head_d[sel] = head_q[sel] + 1'b1;
        last_port_d = sel;
      end
      if (free_fire) begin
        if (free_bad) begin
          free_err_d = 1'b1;
        end else begin
          tail_d[free_port_id] = tail_q[free_port_id] + 1'b1;
        end
      end
    end
    cnt_nx0   = tail_d[0] - head_d[0];
    cnt_nx1   = tail_d[1] - head_d[1];
    tot_d     = TOT_W'(cnt_nx0) + TOT_W'(cnt_nx1);
    intense_d = (state_d == ST_INIT) ? 1'b1 : (tot_d < THRESH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt_q  <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      last_port_q <= 1'b1;
      free_err_q  <= 1'b0;
      intense_q   <= 1'b1;
    end else begin
      init_cnt_q  <= init_cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      last_port_q <= last_port_d;
      free_err_q  <= free_err_d;
      intense_q   <= intense_d;
    end
  end

  // List storage has no reset; INIT rewrites every entry before use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        cell_mem[0][init_cnt_q] <= CELL_ID_WIDTH'(init_cnt_q);
        cell_mem[1][init_cnt_q] <= CELL_ID_WIDTH'(init_cnt_q);
      end else if (free_push) begin
        cell_mem[free_port_id][tail_q[free_port_id][IDX_W-1:0]] <= free_cell_id;
      end
    end
  end

`ifdef PANIC_ALLOC_STATS_EN
  logic [31:0]      alloc_cnt_q, alloc_cnt_d;
  logic [31:0]      fail_cnt_q, fail_cnt_d;
  logic [31:0]      free_cnt_q, free_cnt_d;
  logic [TOT_W-1:0] min_free_q, min_free_d;

  // Saturating event counters and the total-free low-water mark, which is
  // seeded with the full capacity as the block enters RUN.
  always_comb begin
    alloc_cnt_d = alloc_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    free_cnt_d  = free_cnt_q;
    min_free_d  = min_free_q;
    if (alloc_mem_success && alloc_cnt_q != '1) begin
      alloc_cnt_d = alloc_cnt_q + 1'b1;
    end
    if (run && alloc_mem_req && !alloc_mem_success && fail_cnt_q != '1) begin
      fail_cnt_d = fail_cnt_q + 1'b1;
    end
    if (free_push && free_cnt_q != '1) begin
      free_cnt_d = free_cnt_q + 1'b1;
    end
    if (state_q == ST_INIT && state_d == ST_RUN) begin
      min_free_d = TOT_W'(2 * CELLS_PER_PORT);
    end else if (run && tot_d < min_free_q) begin
      min_free_d = tot_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_cnt_q <= '0;
      fail_cnt_q  <= '0;
      free_cnt_q  <= '0;
      min_free_q  <= '0;
    end else begin
      alloc_cnt_q <= alloc_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      free_cnt_q  <= free_cnt_d;
      min_free_q  <= min_free_d;
    end
  end

  assign stat_alloc_cnt = alloc_cnt_q;
  assign stat_fail_cnt  = fail_cnt_q;
  assign stat_free_cnt  = free_cnt_q;
  assign stat_min_free  = min_free_q;
`else
  // Default build carries no statistics state.
`endif

endmodule

// File: tb/tb_panic_cell_allocator.sv
// tb_panic_cell_allocator
//   Directed self-checking bench for panic_cell_allocator with the default
//   parameters (16 cells per port, 2048-byte cells, threshold 4). Expected
//   grants, error pulses and flag values are worked out by hand from the
//   list contents each scenario leaves behind.
module tb_panic_cell_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_mem_req;
  logic [15:0] alloc_mem_size;
  logic [15:0] alloc_cell_id;
  logic        alloc_port_id;
  logic        alloc_mem_success;
  logic        alloc_mem_intense;
  logic        free_valid;
  logic        free_ready;
  logic [15:0] free_cell_id;
  logic        free_port_id;
  logic        free_err;
  logic        init_done;
`ifdef PANIC_ALLOC_STATS_EN
  logic [31:0] stat_alloc_cnt;
  logic [31:0] stat_fail_cnt;
  logic [31:0] stat_free_cnt;
  logic [5:0]  stat_min_free;
`endif

  int assert_count = 0;
  int fail_count   = 0;

  always #5 clk = ~clk;

  panic_cell_allocator dut (
    .clk               (clk),
    .rst               (rst),
    .alloc_mem_req     (alloc_mem_req),
    .alloc_mem_size    (alloc_mem_size),
    .alloc_cell_id     (alloc_cell_id),
    .alloc_port_id     (alloc_port_id),
    .alloc_mem_success (alloc_mem_success),
    .alloc_mem_intense (alloc_mem_intense),
    .free_valid        (free_valid),
    .free_ready        (free_ready),
    .free_cell_id      (free_cell_id),
    .free_port_id      (free_port_id),
    .free_err          (free_err),
    .init_done         (init_done)
`ifdef PANIC_ALLOC_STATS_EN
    ,
    .stat_alloc_cnt    (stat_alloc_cnt),
    .stat_fail_cnt     (stat_fail_cnt),
    .stat_free_cnt     (stat_free_cnt),
    .stat_min_free     (stat_min_free)
`endif
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drives all DUT inputs, then lets combinational outputs settle.
  task automatic applyStimulus(input logic req, input logic [15:0] size,
                               input logic fv, input logic [15:0] fid,
                               input logic fport);
    alloc_mem_req  = req;
    alloc_mem_size = size;
    free_valid     = fv;
    free_cell_id   = fid;
    free_port_id   = fport;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expectGrant(input string tag, input logic port, input logic [15:0] id);
    checkOutput({tag, "_success"}, alloc_mem_success, 1);
    checkOutput({tag, "_port"}, alloc_port_id, port);
    checkOutput({tag, "_id"}, alloc_cell_id, id);
  endtask

  // Counts INIT cycles (bounded) with a stray release held active; the
  // release must be ignored and intense must stay high the whole time.
  task automatic waitInit();
    int n = 0;
    applyStimulus(1'b0, 16'd0, 1'b1, 16'd3, 1'b0);
    while (!init_done && n < 40) begin
      checkOutput("init_intense", alloc_mem_intense, 1);
      checkOutput("init_free_err", free_err, 0);
      checkOutput("init_free_ready", free_ready, 0);
      step();
      n++;
    end
    checkOutput("init_cycles", n, 16);
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    checkOutput("run_free_ready", free_ready, 1);
    checkOutput("run_free_err", free_err, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] sz;
    rst = 1'b1;
    applyStimulus(1'b1, 16'd64, 1'b0, 16'd0, 1'b0);
    step();
    step();
    $display("[TB] reset values");
    checkOutput("rst_init_done", init_done, 0);
    checkOutput("rst_free_ready", free_ready, 0);
    checkOutput("rst_free_err", free_err, 0);
    checkOutput("rst_success", alloc_mem_success, 0);
    checkOutput("rst_intense", alloc_mem_intense, 1);

    rst = 1'b0;
    waitInit();

    $display("[TB] length bounds");
    applyStimulus(1'b1, 16'd0, 1'b0, 16'd0, 1'b0);
    checkOutput("size0_success", alloc_mem_success, 0);
    step();
    applyStimulus(1'b1, 16'd2049, 1'b0, 16'd0, 1'b0);
    checkOutput("size2049_success", alloc_mem_success, 0);
    step();

    // Grant 0 is size 64, grant 1 is exactly one cell; rejected sizes above
    // must not have moved anything, so the pattern starts at port 0 cell 0.
    $display("[TB] back-to-back drain");
    for (int k = 0; k < 32; k++) begin
      sz = (k == 0) ? 16'd64 : ((k == 1) ? 16'd2048 : 16'd1500);
      applyStimulus(1'b1, sz, 1'b0, 16'd0, 1'b0);
      expectGrant($sformatf("drain%0d", k), 1'(k % 2), 16'(k / 2));
      checkOutput($sformatf("drain%0d_intense", k), alloc_mem_intense,
                  ((32 - k) < 4) ? 1 : 0);
      step();
    end
    applyStimulus(1'b1, 16'd1500, 1'b0, 16'd0, 1'b0);
    checkOutput("empty_success", alloc_mem_success, 0);
    checkOutput("empty_intense", alloc_mem_intense, 1);
    step();

    $display("[TB] release while allocating");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 16'd0, 1'b1, 16'(i), 1'b0);
      step();
    end
    applyStimulus(1'b1, 16'd100, 1'b1, 16'd5, 1'b1);
    expectGrant("same_cycle", 1'b0, 16'd0);
    step();
    applyStimulus(1'b1, 16'd100, 1'b0, 16'd0, 1'b0);
    expectGrant("after_rel_a", 1'b0, 16'd1);
    step();
    expectGrant("after_rel_b", 1'b0, 16'd2);
    step();
    expectGrant("returned5", 1'b1, 16'd5);
    step();
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    checkOutput("rel_free_err", free_err, 0);

    $display("[TB] rejected releases");
    applyStimulus(1'b0, 16'd0, 1'b1, 16'd16, 1'b0);
    step();
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    checkOutput("bad_id_err", free_err, 1);
    step();
    checkOutput("bad_id_err_clear", free_err, 0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 16'd0, 1'b1, 16'(i), 1'b1);
      step();
    end
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    checkOutput("refill_err", free_err, 0);
    checkOutput("refill_intense", alloc_mem_intense, 0);
    applyStimulus(1'b0, 16'd0, 1'b1, 16'd7, 1'b1);
    step();
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    checkOutput("full_err", free_err, 1);
    step();
    checkOutput("full_err_clear", free_err, 0);
    applyStimulus(1'b1, 16'd200, 1'b0, 16'd0, 1'b0);
    expectGrant("full_unchanged_a", 1'b1, 16'd0);
    step();
    expectGrant("full_unchanged_b", 1'b1, 16'd1);
    step();

`ifdef PANIC_ALLOC_STATS_EN
    checkOutput("stat_alloc", stat_alloc_cnt, 38);
    checkOutput("stat_fail", stat_fail_cnt, 3);
    checkOutput("stat_free", stat_free_cnt, 21);
    checkOutput("stat_min", 32'(stat_min_free), 0);
`endif

    $display("[TB] reset mid-run");
    rst = 1'b1;
    applyStimulus(1'b1, 16'd64, 1'b1, 16'd2, 1'b0);
    step();
    rst = 1'b0;
    checkOutput("rerst_init_done", init_done, 0);
    checkOutput("rerst_intense", alloc_mem_intense, 1);
`ifdef PANIC_ALLOC_STATS_EN
    checkOutput("rerst_stat_alloc", stat_alloc_cnt, 0);
    checkOutput("rerst_stat_fail", stat_fail_cnt, 0);
    checkOutput("rerst_stat_free", stat_free_cnt, 0);
    checkOutput("rerst_stat_min", 32'(stat_min_free), 0);
`endif
    waitInit();
`ifdef PANIC_ALLOC_STATS_EN
    checkOutput("rerst_stat_min_run", 32'(stat_min_free), 32);
`endif
    applyStimulus(1'b1, 16'd64, 1'b0, 16'd0, 1'b0);
    expectGrant("rerst_first", 1'b0, 16'd0);
    step();
    applyStimulus(1'b1, 16'd64, 1'b0, 16'd0, 1'b0);
    expectGrant("rerst_second", 1'b1, 16'd0);
    step();
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
`ifdef PANIC_ALLOC_STATS_EN
    checkOutput("rerst_stat_alloc_run", stat_alloc_cnt, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
